// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit for EX.
// Shift-add multiply and restoring divide, one bit per cycle.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush                 kill in-flight op, return to IDLE
//   in_valid/in_ready     request handshake (in_op funct3, in_a, in_b, in_tag)
//   out_valid/out_ready   result handshake (out_result, out_tag)
//   busy                  unit is not IDLE
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_MAX = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state;
    logic [2:0]        op;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              a_neg;
    logic              b_neg;
    logic [2*XLEN-1:0] acc;
    logic [CW-1:0]     cnt;
    logic              fin;
    logic              spec;

    assign in_ready = (state == IDLE) && !flush;
    assign busy     = (state != IDLE);

    // Operand decode at accept
    logic            a_sgn;
    logic            b_sgn;
    logic            in_a_neg;
    logic            in_b_neg;
    logic [XLEN-1:0] in_a_mag;
    logic [XLEN-1:0] in_b_mag;
    logic            b_zero;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] spec_res;

    always_comb begin
        a_sgn = (in_op == OP_MUL) || (in_op == OP_MULH) ||
                (in_op == OP_MULHSU) || (in_op == OP_DIV) ||
                (in_op == OP_REM);
        b_sgn = (in_op == OP_MUL) || (in_op == OP_MULH) ||
                (in_op == OP_DIV) || (in_op == OP_REM);
        in_a_neg = a_sgn && in_a[XLEN-1];
        in_b_neg = b_sgn && in_b[XLEN-1];
        in_a_mag = in_a_neg ? -in_a : in_a;
        in_b_mag = in_b_neg ? -in_b : in_b;
        b_zero   = (in_b == '0);
        ovf      = ((in_op == OP_DIV) || (in_op == OP_REM)) &&
                   (in_a == MIN_INT) && (in_b == '1);
        special  = in_op[2] && (b_zero || ovf);
        if (b_zero)
            spec_res = in_op[1] ? in_a : '1;
        else
            spec_res = in_op[1] ? '0 : MIN_INT;
    end

    // One iteration step
    logic [2*XLEN-1:0] mul_add;
    logic [2*XLEN-1:0] mul_step;
    logic [XLEN:0]     trial;
    logic              ge;
    logic [XLEN-1:0]   rem_sub;
    logic [2*XLEN-1:0] div_step;

    // Divide packs remainder in acc high half, quotient in low half
    always_comb begin
        mul_add  = b_mag[cnt] ? {{XLEN{1'b0}}, a_mag} : '0;
        mul_step = {acc[2*XLEN-2:0], 1'b0} + mul_add;
        trial    = {acc[2*XLEN-1:XLEN], a_mag[cnt]};
        ge       = (trial >= {1'b0, b_mag});
        rem_sub  = trial[XLEN-1:0] - b_mag;
        div_step = {ge ? rem_sub : trial[XLEN-1:0],
                    acc[XLEN-2:0], ge};
    end

    // Sign fix and result select
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fix_result;

    always_comb begin
        prod = (a_neg ^ b_neg) ? -acc : acc;
        quo  = (a_neg ^ b_neg) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = a_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        fix_result = '0;
        unique case (1'b1)
            (op == OP_MUL):            fix_result = prod[XLEN-1:0];
            (!op[2] && op != OP_MUL):  fix_result = prod[2*XLEN-1:XLEN];
            (op[2] && !op[1]):         fix_result = quo;
            (op[2] && op[1]):          fix_result = rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op         <= '0;
            a_mag      <= '0;
            b_mag      <= '0;
            a_neg      <= 1'b0;
            b_neg      <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            fin        <= 1'b0;
            spec       <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            fin       <= 1'b0;
            spec      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op      <= in_op;
                        out_tag <= in_tag;
                        state   <= CALC;
                        if (special) begin
                            // Fast path: one pass through CALC
                            // with the result already known.
                            out_result <= spec_res;
                            spec       <= 1'b1;
                            fin        <= 1'b1;
                        end else begin
                            a_mag <= in_a_mag;
                            b_mag <= in_b_mag;
                            a_neg <= in_a_neg;
                            b_neg <= in_b_neg;
                            acc   <= '0;
                            cnt   <= CNT_MAX;
                            spec  <= 1'b0;
                            fin   <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    if (fin) begin
                        if (!spec)
                            out_result <= fix_result;
                        out_valid <= 1'b1;
                        fin       <= 1'b0;
                        spec      <= 1'b0;
                        state     <= DONE;
                    end else begin
                        acc <= op[2] ? div_step : mul_step;
                        if (cnt == '0)
                            fin <= 1'b1;
                        else
                            cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: vector table, corner sequences and random ops
// checked against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int XL = 32;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_op = '0;
    logic [XL-1:0] in_a = '0;
    logic [XL-1:0] in_b = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [XL-1:0] out_result;
    logic [TW-1:0] out_tag;
    logic          busy;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(XL), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model from the RISC-V M-extension rules
    function automatic void model(input logic [2:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] res,
                                  output int lat);
        logic [63:0] sa, sb, p;
        int ia, ib;
        ia  = a;
        ib  = b;
        lat = 33;
        res = '0;
        if (op < 3'd4) begin
            sa = (op == 3'd3) ? {32'd0, a} : {{32{a[31]}}, a};
            sb = (op >= 3'd2) ? {32'd0, b} : {{32{b[31]}}, b};
            p  = sa * sb;
            res = (op == 3'd0) ? p[31:0] : p[63:32];
        end else if (b == 0) begin
            lat = 1;
            res = (op >= 3'd6) ? a : 32'hFFFF_FFFF;
        end else if ((op == 3'd4 || op == 3'd6) &&
                     a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lat = 1;
            res = (op == 3'd4) ? 32'h8000_0000 : 32'd0;
        end else begin
            case (op)
                3'd4:    res = ia / ib;
                3'd5:    res = a / b;
                3'd6:    res = ia % ib;
                default: res = a % b;
            endcase
        end
    endfunction

    // Issue one op, wait for result, hold out_ready low for stall cycles
    task automatic run_op(input string nm, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [TW-1:0] tag, input int stall,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        int w;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk({nm, " in_ready"}, in_ready, 1);
        out_ready = (stall == 0);
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
        in_tag = tag;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, " latency"}, lat, exp_lat);
        chk({nm, " result"}, out_result, exp);
        chk({nm, " tag"}, out_tag, tag);
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1;
            chk({nm, " held valid"}, out_valid, 1);
            chk({nm, " held result"}, out_result, exp);
            chk({nm, " held tag"}, out_tag, tag);
            chk({nm, " in_ready in DONE"}, in_ready, 0);
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({nm, " valid drop"}, out_valid, 0);
        chk({nm, " idle"}, busy, 0);
    endtask

    typedef struct {
        string       nm;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'd0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = $urandom_range(0, 20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        logic [31:0] r_exp;
        int r_lat;
        logic saw;

        tbl.push_back('{"mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
        tbl.push_back('{"mulh", 3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33});
        tbl.push_back('{"mulhsu", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33});
        tbl.push_back('{"mulhu", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 33});
        tbl.push_back('{"div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33});
        tbl.push_back('{"rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33});
        tbl.push_back('{"divu", 3'd5, 32'hFFFF_FFFE, 32'd3, 32'h5555_5554, 33});
        tbl.push_back('{"div0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1});
        tbl.push_back('{"remu0", 3'd7, 32'd5, 32'd0, 32'd5, 1});
        tbl.push_back('{"divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        tbl.push_back('{"removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1});
        tbl.push_back('{"divu_big", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33});
        tbl.push_back('{"remu_big", 3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33});
        tbl.push_back('{"mul_m1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 33});
        tbl.push_back('{"rem_neg_b", 3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 33});

        #12;
        chk("reset out_valid", out_valid, 0);
        chk("reset out_result", out_result, 0);
        chk("reset out_tag", out_tag, 0);
        chk("reset busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset in_ready", in_ready, 1);

        foreach (tbl[i])
            run_op(tbl[i].nm, tbl[i].op, tbl[i].a, tbl[i].b,
                   TW'(i + 1), 0, tbl[i].exp, tbl[i].lat);

        // Back-pressure in DONE
        run_op("bp", 3'd0, 32'd1234, 32'd5678, 5'h15, 10,
               32'd7006652, 33);

        // Flush at CALC cycle 12 with a request pending
        @(negedge clk);
        in_valid = 1'b1;
        in_op = 3'd0;
        in_a = 32'd3;
        in_b = 32'd4;
        in_tag = 5'h0A;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1;
        in_op = 3'd4;
        in_b = 32'd0;
        #1;
        chk("flush in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        chk("flush busy", busy, 0);
        chk("flush out_valid", out_valid, 0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) saw = 1'b1;
        end
        chk("flush no result", saw, 0);

        // Flush in IDLE is harmless
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        run_op("after_flush", 3'd5, 32'd100, 32'd7, 5'h03, 0, 32'd14, 33);

        // Async reset mid-CALC
        @(negedge clk);
        in_valid = 1'b1;
        in_op = 3'd1;
        in_a = 32'hDEAD_BEEF;
        in_b = 32'h1234_5678;
        in_tag = 5'h1F;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst busy", busy, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_result", out_result, 0);
        chk("rst out_tag", out_tag, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random ops against the model
        for (int n = 0; n < 120; n++) begin
            logic [2:0] op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            model(op, a, b, r_exp, r_lat);
            run_op($sformatf("rnd%0d op%0d", n, op), op, a, b,
                   TW'($urandom), ($urandom_range(0, 3) == 0) ? 2 : 0,
                   r_exp, r_lat);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
